// File: rtl/led_fader.sv
// Six-channel PWM LED fader: each active-low request ramps a per-channel level toward `bright`
// or 0, and the PWM frames drive active-low pins. Define LED_FADER_GAMMA_EN for gamma-corrected duty.
module led_fader #(
  parameter int unsigned PWM_PERIOD = 255,
  parameter int unsigned FADE_DIV   = 26_470,
  parameter int unsigned FADE_STEP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] nLed_in,
  input  logic [7:0] bright,
  output logic [5:0] nLed,
  output logic       fade_busy
);

  localparam int unsigned    FdW     = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [FdW-1:0] FdLast  = FdW'(FADE_DIV - 1);
  localparam logic [FdW-1:0] FdOne   = FdW'(1);
  localparam logic [7:0]     PwmLast = 8'(PWM_PERIOD - 1);
  localparam logic [8:0]     Step9   = 9'(FADE_STEP);
  localparam logic [7:0]     Step8   = 8'(FADE_STEP);

  logic [FdW-1:0]  fade_cnt_q, fade_cnt_d;
  logic            fade_tick;
  logic [7:0]      pwm_cnt_q, pwm_cnt_d;
  logic            frame_end;
  logic [5:0][7:0] level_q, level_d;
  logic [5:0][7:0] duty_q, duty_d;
  logic [5:0][7:0] target;
  logic [5:0][7:0] duty_val;
  logic [5:0]      nled_q, nled_d;
  logic            busy_q, busy_d;

  always_comb begin
    fade_tick  = (fade_cnt_q == FdLast);
    fade_cnt_d = fade_tick ? '0 : fade_cnt_q + FdOne;
    frame_end  = (pwm_cnt_q == PwmLast);
    pwm_cnt_d  = frame_end ? 8'd0 : pwm_cnt_q + 8'd1;
  end

`ifdef LED_FADER_GAMMA_EN
  logic [5:0][15:0] sq;

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      sq[i] = 16'(level_q[i]) * 16'(level_q[i]);
      // Full scale is special-cased so a fully-on channel stays solidly lit.
      duty_val[i] = (level_q[i] == 8'hFF) ? 8'hFF : sq[i][15:8];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      duty_val[i] = level_q[i];
    end
  end
`endif

  always_comb begin
    logic [8:0] up9;
    busy_d = 1'b0;
    up9    = '0;
    for (int i = 0; i < 6; i++) begin
      target[i]  = nLed_in[i] ? 8'd0 : bright;
      level_d[i] = level_q[i];
      // 9-bit compare keeps the step from wrapping past 0 or 255.
      if (fade_tick) begin
        if (level_q[i] < target[i]) begin
          up9        = {1'b0, level_q[i]} + Step9;
          level_d[i] = (up9 >= {1'b0, target[i]}) ? target[i] : up9[7:0];
        end else if (level_q[i] > target[i]) begin
          level_d[i] = (({1'b0, target[i]} + Step9) >= {1'b0, level_q[i]}) ?
                       target[i] : level_q[i] - Step8;
        end
      end
      // Shadow loads only at frame end, so an in-progress frame never changes.
      duty_d[i] = frame_end ? duty_val[i] : duty_q[i];
      nled_d[i] = ~(pwm_cnt_q < duty_q[i]);
      busy_d    = busy_d | (level_q[i] != target[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fade_cnt_q <= '0;
      pwm_cnt_q  <= 8'd0;
      level_q    <= '0;
      duty_q     <= '0;
      nled_q     <= 6'h3F;
      busy_q     <= 1'b0;
    end else begin
      fade_cnt_q <= fade_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      level_q    <= level_d;
      duty_q     <= duty_d;
      nled_q     <= nled_d;
      busy_q     <= busy_d;
    end
  end

  assign nLed      = nled_q;
  assign fade_busy = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader (FADE_DIV=4, FADE_STEP=1): vector table of settled duty counts
// plus hand sequences for reset, fade timing, reversal, frame alignment and mid-ramp reset.
module tb_led_fader;

  logic       clk    = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n  = 1'b1;
  logic [5:0] nled_in = 6'h3F;
  logic [7:0] bright  = 8'hFF;
  logic [5:0] nled;
  logic       fade_busy;

  int cyc;
  int tests  = 0;
  int failed = 0;

`ifdef LED_FADER_GAMMA_EN
  localparam int ExpD64 = 16;
  localparam int ExpD32 = 4;
`else
  localparam int ExpD64 = 64;
  localparam int ExpD32 = 32;
`endif

  led_fader #(
    .PWM_PERIOD(255),
    .FADE_DIV  (4),
    .FADE_STEP (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .nLed_in  (nled_in),
    .bright   (bright),
    .nLed     (nled),
    .fade_busy(fade_busy)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Edges since reset release; edge k leaves pwm_cnt = k mod 255 and fade_cnt = k mod 4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    logic [5:0] nin;
    logic [7:0] br;
    int         lin;
    int         gam;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async_nled", int'(nled), 'h3F);
    chk("reset_async_busy", int'(fade_busy), 0);
    #1 rst_n = 1'b1;
  endtask

  task automatic count_frame(output int lows[6]);
    for (int c = 0; c < 6; c++) lows[c] = 0;
    for (int n = 0; n < 255; n++) begin
      @(negedge clk);
      for (int c = 0; c < 6; c++) if (nled[c] == 1'b0) lows[c]++;
    end
  endtask

  task automatic wait_busy_low(input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (fade_busy == 1'b0) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int bad, low, k0, first, ka, at, exp_d;
    int lows[6];

    vecs[0] = '{6'h3E, 8'd255, 255, 255};
    vecs[1] = '{6'h3B, 8'd64,  64,  16};
    vecs[2] = '{6'h3D, 8'd255, 255, 255};
    vecs[3] = '{6'h3D, 8'd32,  32,  4};
    vecs[4] = '{6'h00, 8'd128, 128, 64};
    vecs[5] = '{6'h2A, 8'd200, 200, 156};
    vecs[6] = '{6'h3E, 8'd15,  15,  0};
    vecs[7] = '{6'h3E, 8'd16,  16,  1};
    vecs[8] = '{6'h3F, 8'd255, 255, 255};
    vecs[9] = '{6'h1E, 8'd100, 100, 39};

    // Idle reset with the clock stopped.
    #5 rst_n = 1'b0;
    #1;
    chk("idle_reset_nled", int'(nled), 'h3F);
    chk("idle_reset_busy", int'(fade_busy), 0);
    #10 rst_n = 1'b1;
    clk_en = 1'b1;
    bad = 0;
    for (int n = 0; n < 10_000; n++) begin
      @(negedge clk);
      if (nled !== 6'h3F || fade_busy !== 1'b0) bad++;
    end
    chk("idle_hold_bad_cycles", bad, 0);

    // Full fade-in of channel 0.
    nled_in = 6'h3E;
    k0      = cyc;
    first   = (k0 / 4 + 1) * 4;
    @(negedge clk);
    chk("fadein_busy_rise", int'(fade_busy), 1);
    wait_busy_low(1200, at);
    chk("fadein_busy_fall_cycle", at, first + 1017);
    repeat (520) @(negedge clk);
    count_frame(lows);
    chk("fadein_ch0_low", lows[0], 255);
    chk("fadein_other_low", lows[1] + lows[2] + lows[3] + lows[4] + lows[5], 0);

    // Reversal at level 100.
    nled_in = 6'h3F;
    do_reset();
    @(negedge clk);
    nled_in = 6'h3E;
    k0      = cyc;
    first   = (k0 / 4 + 1) * 4;
    ka      = first + 396;
    for (int n = 0; n < 500 && cyc != ka; n++) @(negedge clk);
    chk("reverse_reach_level100", cyc, ka);
    nled_in = 6'h3F;
    @(negedge clk);
    chk("reverse_busy_held", int'(fade_busy), 1);
    wait_busy_low(600, at);
    chk("reverse_busy_fall_cycle", at, ka + 401);
    repeat (520) @(negedge clk);
    count_frame(lows);
    chk("reverse_ch0_low", lows[0], 0);

    // Duty alignment, channel 2 at bright=64.
    bright  = 8'd64;
    nled_in = 6'h3B;
    do_reset();
    repeat (1000) @(negedge clk);
    bad = 0;
    low = 0;
    for (int n = 0; n < 255; n++) begin
      @(negedge clk);
      if ((nled[2] == 1'b0) != (((cyc - 1) % 255) < ExpD64)) bad++;
      if (nled[2] == 1'b0) low++;
    end
    chk("align_ch2_bad_cycles", bad, 0);
    chk("align_ch2_low", low, ExpD64);

    // Settled duty table.
    for (int v = 0; v < 10; v++) begin
      nled_in = vecs[v].nin;
      bright  = vecs[v].br;
      repeat (1800) @(negedge clk);
      chk($sformatf("vec%0d_busy", v), int'(fade_busy), 0);
      count_frame(lows);
`ifdef LED_FADER_GAMMA_EN
      exp_d = vecs[v].gam;
`else
      exp_d = vecs[v].lin;
`endif
      for (int c = 0; c < 6; c++)
        chk($sformatf("vec%0d_ch%0d_low", v, c), lows[c], vecs[v].nin[c] ? 0 : exp_d);
    end

    // Step-down 255 -> 32 on channel 1, reset mid-ramp, ramp restarts from 0.
    nled_in = 6'h3D;
    bright  = 8'd255;
    repeat (1800) @(negedge clk);
    bright = 8'd32;
    repeat (100) @(negedge clk);
    do_reset();
    wait_busy_low(300, at);
    chk("midreset_busy_fall_cycle", at, 129);
    repeat (520) @(negedge clk);
    count_frame(lows);
    chk("midreset_ch1_low", lows[1], ExpD32);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
